// File: rtl/serial_sub32.sv
// rtl/serial_sub32.sv - digit-serial D = A - B - Bin, CHUNK bits per clock; optional Z flag via SERIAL_SUB_ZERO_FLAG_EN
module serial_sub32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  output logic             OV,
  output logic             Z
`else
  output logic             OV
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] diff;
  logic [CHUNK:0]   sum;
  logic             borrow_nxt;
  logic             last;
  logic             accept;

  // Operands are shifted right each CALC cycle, so the active slice is always the low CHUNK bits.
  assign a_sl       = a_sh[CHUNK-1:0];
  assign b_sl       = b_sh[CHUNK-1:0];
  assign sum        = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, ~borrow};
  assign diff       = sum[CHUNK-1:0];
  assign borrow_nxt = ~sum[CHUNK];
  assign last       = (cnt == LAST);
  assign accept     = (state == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice subtract and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
      OV     <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      Z      <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      borrow <= Bin;
      cnt    <= '0;
    end else if (state == CALC) begin
      a_sh   <= a_sh >> CHUNK;
      b_sh   <= b_sh >> CHUNK;
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
      for (int i = 0; i < NCHUNK; i++) begin
        if (cnt == CW'(i)) D[i*CHUNK +: CHUNK] <= diff;
      end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      if (cnt == '0) Z <= (diff == '0);
      else           Z <= Z & (diff == '0);
`endif
      // On the top slice the slice MSBs are the operand sign bits.
      if (last) begin
        Bout <= borrow_nxt;
        OV   <= (a_sl[CHUNK-1] != b_sl[CHUNK-1]) && (diff[CHUNK-1] != a_sl[CHUNK-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub32.sv
// tb/tb_serial_sub32.sv - scoreboard bench for serial_sub32
module tb_serial_sub32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        OV;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic        Z;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t sb[$];

  serial_sub32 #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .Bin(Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D(D),
    .Bout(Bout),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    .OV(OV),
    .Z(Z)
`else
    .OV(OV)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    exp_t e;
    r      = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    e.d    = r[31:0];
    e.bout = r[32];
    e.ov   = (a[31] != b[31]) && (r[31] != a[31]);
    e.z    = (r[31:0] == 32'd0);
    return e;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input int stall, input bit toggle);
    exp_t e;
    int   cyc;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    sb.push_back(model(a, b, bin));
    A         = a;
    B         = b;
    Bin       = bin;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (toggle) begin
        in_valid = ~in_valid;
        A        = $urandom;
        B        = $urandom;
        Bin      = ~Bin;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", cyc, 4);
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("D", D, e.d);
      check("Bout", Bout, e.bout);
      check("OV", OV, e.ov);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      check("Z", Z, e.z);
`endif
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_D", D, e.d);
        check("stall_Bout", Bout, e.bout);
        check("stall_OV", OV, e.ov);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_D_hold", D, e.d);
      check("post_Bout_hold", Bout, e.bout);
      check("post_OV_hold", OV, e.ov);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_Bout", Bout, 0);
    check("rst_OV", OV, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("rst_Z", Z, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_op(32'd10, 32'd3, 1'b1, 0, 1'b0);
    do_op(32'd3, 32'd10, 1'b0, 0, 1'b0);
    do_op(32'd0, 32'd0, 1'b1, 0, 1'b0);
    do_op(32'd5, 32'd5, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b0, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);

    // Backpressure with in_valid noise during CALC, then back-to-back issue.
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 10, 1'b1);
    do_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

    // Abort mid-CALC with reset.
    @(negedge clk);
    A        = 32'hFFFF_FFFF;
    B        = 32'd0;
    Bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_D", D, 0);
    check("abort_Bout", Bout, 0);
    check("abort_OV", OV, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end

    do_op(32'd1200, 32'd500, 1'b1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub32.md
Name: serial_sub32

Overview:
- Digit-serial two's-complement subtractor computing D = A - B - Bin, CHUNK bits per clock.
- Runs in the inverse direction to the 32-bit carry-lookahead adder and shares its operand/flag naming (A, B, borrow-in/out in place of Cin/Cout).
- Used where a full-width single-cycle subtract is too costly. Valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 32, operand and result width.
- CHUNK, 8, bits processed per CALC cycle. WIDTH must be a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference, A - B - Bin mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff unsigned A < B + Bin.
- OV  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, D=0, Bout=0, OV=0, chunk counter=0, internal borrow=0. Asserting rst mid-operation aborts it. No result is produced, and the next operation starts clean.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid=1 on a clock edge, register A, B and Bin; set borrow=Bin and cnt=0; go to CALC. Inputs are not sampled again until the next IDLE.
- CALC: in_ready=0, out_valid=0. Each edge computes {borrow_n, diff} = A[cnt] - B[cnt] - borrow over CHUNK-bit slice cnt (LSB slice first). The result equals A_slice + ~B_slice + ~borrow with the carry inverted. diff is written to D slice cnt, borrow takes borrow_n, and cnt increments.
- On the edge where cnt = NCHUNK-1:
  - Bout = final borrow.
  - OV = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), evaluated on the final MSB.
  - Go to DONE.
- DONE: out_valid=1 and D, Bout, OV are stable. When out_ready=1 on an edge, go to IDLE with out_valid=0; D, Bout and OV hold their values. When out_ready=0, hold indefinitely.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (4 with defaults). Minimum issue interval is NCHUNK+2 cycles.
- D is only valid while out_valid=1. Partial slices may be visible during CALC.
- in_valid while not in IDLE is ignored; the upstream source must hold its data until in_ready.
- Bin=1 with A=B gives D = all ones and Bout=1.
- CHUNK=WIDTH is legal: NCHUNK=1, and the block degenerates to a one-cycle CALC.

Optional Feature:
- Macro SERIAL_SUB_ZERO_FLAG_EN.
- When defined, an extra output port Z (1 bit) is added. Z = 1 iff D == 0, accumulated per slice during CALC: set on the first slice, then ANDed with each subsequent slice-zero result. Z is valid with out_valid, resets to 0, and holds after the handshake.
- When undefined, the Z port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, then A=10, B=3, Bin=1, out_ready=1 -> out_valid high 4 cycles after accept; D=6, Bout=0, OV=0 (Z=0).
- A=3, B=10, Bin=0 -> D=0xFFFFFFF9, Bout=1, OV=0.
- A=0, B=0, Bin=1 -> D=0xFFFFFFFF, Bout=1, OV=0. Also A=5, B=5, Bin=0 -> D=0, Bout=0 (Z=1).
- A=0x80000000, B=1, Bin=0 -> D=0x7FFFFFFF, Bout=0, OV=1. A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, Bout=1, OV=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid, D, Bout and OV stable and in_ready=0 throughout. Raise out_ready -> IDLE next cycle, and a new op is accepted on the following edge. in_valid toggled during CALC -> ignored.
- Assert rst on CALC cycle 2 -> all outputs return to reset values immediately, in_ready=1. A subsequent op A=1200, B=500, Bin=1 -> D=699, Bout=0.
